// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one W-bit adder between N_REQ requesters.
// One registered result stage; the result is tagged with the id of the winning requester.
// Optional feature macro ADDER_ARB_CHAIN_EN: carry-chaining, in which one requester holds
// the adder for multi-word additions and the stored carry feeds its next beat.
module adder_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  localparam int unsigned IdW  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_cin,
  input  logic [N_REQ-1:0]   req_chain,
  output logic               rsp_valid,
  output logic [IdW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_sum,
  output logic               rsp_cout,
  output logic               chain_busy
);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic           rr_vld;
  logic [IdW-1:0] rr_idx;
  logic           grant_vld;
  logic [IdW-1:0] grant_idx;
  logic           eff_cin;
  logic [W-1:0]   a_arr [N_REQ];
  logic [W-1:0]   b_arr [N_REQ];
  logic [W:0]     sum_full;

  logic           rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;

`ifdef ADDER_ARB_CHAIN_EN
  typedef enum logic [0:0] {StIdle, StChain} state_e;
  state_e         state_q, state_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic           carry_q, carry_d;
`else
  // Chaining is compiled out; the input is intentionally ignored.
  logic unused_chain;
  assign unused_chain = ^req_chain;
`endif

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  // Round-robin search: first valid requester at or above ptr, with wrap-around.
  always_comb begin
    int unsigned    cand;
    logic [IdW-1:0] cand_idx;
    rr_vld   = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IdW'(cand);
      if (!rr_vld && req_valid[cand_idx]) begin
        rr_vld = 1'b1;
        rr_idx = cand_idx;
      end
    end
  end

  // Grant selection, one-hot ready and the effective carry-in of the granted beat.
  always_comb begin
    grant_vld = rr_vld;
    grant_idx = rr_idx;
    eff_cin   = req_cin[rr_idx];
`ifdef ADDER_ARB_CHAIN_EN
    if (state_q == StChain) begin
      // Only the owner may proceed; a dropped valid stalls everyone.
      grant_vld = req_valid[owner_q];
      grant_idx = owner_q;
      eff_cin   = carry_q;
    end
`endif
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign sum_full = {1'b0, a_arr[grant_idx]} + {1'b0, b_arr[grant_idx]} + {{W{1'b0}}, eff_cin};

  // Next-state for pointer and response stage; results hold when nothing is granted.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (grant_vld) begin
      // During a chain this re-writes owner+1 every beat, which keeps ptr effectively frozen.
      ptr_d       = (grant_idx == IdW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_sum_d   = sum_full[W-1:0];
      rsp_cout_d  = sum_full[W];
    end
  end

`ifdef ADDER_ARB_CHAIN_EN
  // Chain FSM next-state: enter on a chained beat in IDLE, leave on the owner's last beat.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    carry_d = carry_q;
    if (grant_vld) begin
      carry_d = sum_full[W];
      if (state_q == StIdle) begin
        if (req_chain[grant_idx]) begin
          state_d = StChain;
          owner_d = grant_idx;
        end
      end else if (!req_chain[grant_idx]) begin
        state_d = StIdle;
      end
    end
  end

  // Chain FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      carry_q <= carry_d;
    end
  end

  assign chain_busy = (state_q == StChain);
`else
  assign chain_busy = 1'b0;
`endif

  // Pointer and registered response stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (N_REQ=4, W=32). Chain scenarios run when
// ADDER_ARB_CHAIN_EN is defined; otherwise the chain-ignored scenario runs.
module tb_adder_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_chain;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           chain_busy;

  int n_cmp = 0;
  int n_bad = 0;

  adder_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_chain  (req_chain),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .chain_busy (chain_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic ch);
    req_valid[i]     = v;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_cin[i]       = cin;
    req_chain[i]     = ch;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [W-1:0] s, input logic c);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, ".id"},    64'(rsp_id),    64'(id));
    chk({tag, ".sum"},   64'(rsp_sum),   64'(s));
    chk({tag, ".cout"},  64'(rsp_cout),  64'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_chain = '0;
    #12;

    // Reset values, and combinational grant from ptr=0 while held in reset.
    chk_rsp("reset", 1'b0, 2'd0, 32'h0, 1'b0);
    chk("reset.busy", 64'(chain_busy), 64'd0);
    chk("reset.ready_none", 64'(req_ready), 64'h0);
    req_valid = 4'b0110;
    #1;
    chk("reset.ready_rr", 64'(req_ready), 64'b0010);
    req_valid = '0;

    // Release reset away from the clock edge.
    tick();
    rst_n = 1'b1;

    // Single beat, no contention: 0xFFFFFFFF + 1 wraps with carry out.
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1;
    chk("single.ready", 64'(req_ready), 64'b0001);
    tick();
    chk_rsp("single.rsp", 1'b1, 2'd0, 32'h0, 1'b1);
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_rsp("idle.hold", 1'b0, 2'd0, 32'h0, 1'b1);

    // ptr=1: lone req3 with cin=1 -> 0x7FFFFFFF+0x7FFFFFFF+1 = 0xFFFFFFFF, cout 0; ptr -> 0.
    set_req(3, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
    #1;
    chk("req3.ready", 64'(req_ready), 64'b1000);
    tick();
    chk_rsp("req3.rsp", 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0);

    // All four valid: grants rotate 0,1,2,3,0,1 and responses follow one cycle later.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i), 32'h10, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr.ready%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      tick();
      chk_rsp($sformatf("rr.rsp%0d", k), 1'b1, 2'(k % 4), 32'h10 + 32'(k % 4), 1'b0);
    end
    req_valid = '0;
    tick();  // ptr is now 2
    chk("rr.drain", 64'(rsp_valid), 64'd0);

`ifdef ADDER_ARB_CHAIN_EN
    // Chain from ptr=2: req2 holds the adder for two beats, req1 waits.
    set_req(1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    #1;
    chk("chain.b1.ready", 64'(req_ready), 64'b0100);
    chk("chain.b1.busy", 64'(chain_busy), 64'd0);
    tick();
    chk_rsp("chain.b1.rsp", 1'b1, 2'd2, 32'h0, 1'b1);
    chk("chain.b2.busy", 64'(chain_busy), 64'd1);
    set_req(2, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("chain.b2.ready", 64'(req_ready), 64'b0100);
    tick();
    chk_rsp("chain.b2.rsp", 1'b1, 2'd2, 32'h1, 1'b0);
    chk("chain.end.busy", 64'(chain_busy), 64'd0);
    set_req(2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("chain.req1.ready", 64'(req_ready), 64'b0010);
    tick();
    chk_rsp("chain.req1.rsp", 1'b1, 2'd1, 32'd11, 1'b0);
    // ptr is now 2.

    // Stall: owner req2 drops valid for 3 cycles while everyone else is valid.
    set_req(0, 1'b1, 32'd7, 32'd7, 1'b0, 1'b0);
    set_req(1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    set_req(3, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    #1;
    chk("stall.b1.ready", 64'(req_ready), 64'b0100);
    tick();
    chk_rsp("stall.b1.rsp", 1'b1, 2'd2, 32'h0, 1'b1);
    req_valid[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall.ready%0d", k), 64'(req_ready), 64'h0);
      chk($sformatf("stall.busy%0d", k), 64'(chain_busy), 64'd1);
      tick();
      chk($sformatf("stall.rspv%0d", k), 64'(rsp_valid), 64'd0);
    end
    // Resume: cin=0 on the port but stored carry=1 applies: 2+3+1 = 6.
    set_req(2, 1'b1, 32'd2, 32'd3, 1'b0, 1'b0);
    #1;
    chk("stall.resume.ready", 64'(req_ready), 64'b0100);
    tick();
    chk_rsp("stall.resume.rsp", 1'b1, 2'd2, 32'd6, 1'b0);
    chk("stall.resume.busy", 64'(chain_busy), 64'd0);
    set_req(2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // ptr=3: chain from the last index; after it ends the pointer wraps to 0.
    #1;
    chk("wrap.b1.ready", 64'(req_ready), 64'b1000);
    tick();
    chk_rsp("wrap.b1.rsp", 1'b1, 2'd3, 32'h0, 1'b1);
    set_req(3, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_rsp("wrap.b2.rsp", 1'b1, 2'd3, 32'h1, 1'b0);
    set_req(3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("wrap.next.ready", 64'(req_ready), 64'b0001);

    // Reset mid-chain: req0 starts a chain, reset hits while the chain is active.
    set_req(0, 1'b1, 32'd7, 32'd7, 1'b0, 1'b1);
    set_req(3, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    tick();
    chk_rsp("rstc.b1.rsp", 1'b1, 2'd0, 32'd14, 1'b0);
    chk("rstc.busy", 64'(chain_busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rsp("rstc.async", 1'b0, 2'd0, 32'h0, 1'b0);
    chk("rstc.async.busy", 64'(chain_busy), 64'd0);
    req_valid[0] = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("rstc.after.ready", 64'(req_ready), 64'b0010);
    tick();
    chk_rsp("rstc.after.rsp", 1'b1, 2'd1, 32'd11, 1'b0);
`else
    // In-flight result discarded by an asynchronous reset (ptr=2).
    set_req(2, 1'b1, 32'd10, 32'd20, 1'b1, 1'b0);
    tick();
    chk_rsp("rst.inflight", 1'b1, 2'd2, 32'd31, 1'b0);
    set_req(2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rsp("rst.async", 1'b0, 2'd0, 32'h0, 1'b0);

    // Chain ignored: req0 with chain=1, cin=1, 1+1+1 = 3; req1 wins next, no hold.
    set_req(0, 1'b1, 32'd1, 32'd1, 1'b1, 1'b1);
    set_req(1, 1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
    #1;
    chk("off.rst.ready", 64'(req_ready), 64'b0001);
    rst_n = 1'b1;
    tick();
    chk_rsp("off.b0.rsp", 1'b1, 2'd0, 32'd3, 1'b0);
    chk("off.busy", 64'(chain_busy), 64'd0);
    chk("off.next.ready", 64'(req_ready), 64'b0010);
    tick();
    chk_rsp("off.b1.rsp", 1'b1, 2'd1, 32'd8, 1'b0);
    chk("off.busy2", 64'(chain_busy), 64'd0);
`endif

    req_valid = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
